// File: rtl/mcdf_pkg.sv
// Shared types and helpers for the MCDF channel arbiter.
package mcdf_pkg;

    localparam int MCDF_DATA_W   = 32;
    localparam int MCDF_ID_W     = 2;
    localparam int MCDF_PRIO_W   = 2;
    localparam int MCDF_PKGLEN_W = 3;
    localparam int MCDF_CNT_W    = 6;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

    // Package length in beats; selects above 3 saturate at 32.
    function automatic logic [MCDF_CNT_W-1:0] pkglen_decode(input logic [MCDF_PKGLEN_W-1:0] sel);
        case (sel)
            3'd0:    return 6'd4;
            3'd1:    return 6'd8;
            3'd2:    return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/mcdf_arb_picker.sv
// Combinational winner select: lowest priority value among requesters,
// ties broken by the first requester after rr_ptr_i (modulo NUM_CH).
module mcdf_arb_picker
    import mcdf_pkg::*;
#(
    parameter int NUM_CH = 3
) (
    input  logic [NUM_CH-1:0]             req_i,
    input  logic [NUM_CH*MCDF_PRIO_W-1:0] prio_i,
    input  logic [MCDF_ID_W-1:0]          rr_ptr_i,
    output logic [MCDF_ID_W-1:0]          win_id_o,
    output logic                          win_vld_o
);

    logic [MCDF_PRIO_W-1:0] min_prio;

    always_comb begin
        min_prio = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_i[i] && (prio_i[MCDF_PRIO_W*i +: MCDF_PRIO_W] < min_prio)) begin
                min_prio = prio_i[MCDF_PRIO_W*i +: MCDF_PRIO_W];
            end
        end
    end

    always_comb begin
        int idx;
        idx       = 0;
        win_id_o  = '0;
        win_vld_o = 1'b0;
        // Scan starting one past the pointer, wrapping once around the channels.
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = int'(rr_ptr_i) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            for (int j = 0; j < NUM_CH; j++) begin
                if ((j == idx) && !win_vld_o && req_i[j] &&
                    (prio_i[MCDF_PRIO_W*j +: MCDF_PRIO_W] == min_prio)) begin
                    win_vld_o = 1'b1;
                    win_id_o  = MCDF_ID_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/mcdf_arbiter.sv
// MCDF channel arbiter: picks one slave channel per package and streams it to the formatter.
// Define ARB_RR_EN for round-robin tie-break; otherwise ties go to the lowest channel id.
module mcdf_arbiter
    import mcdf_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DATA_W = MCDF_DATA_W
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic [NUM_CH-1:0]                 slv_req_i,
    input  logic [NUM_CH-1:0]                 slv_val_i,
    input  logic [NUM_CH*DATA_W-1:0]          slv_data_i,
    input  logic [NUM_CH*MCDF_PRIO_W-1:0]     slv_prio_i,
    input  logic [NUM_CH*MCDF_PKGLEN_W-1:0]   slv_pkglen_i,
    output logic [NUM_CH-1:0]                 a2s_ack_o,
    input  logic                              f2a_id_req_i,
    input  logic                              f2a_ack_i,
    output logic                              a2f_val_o,
    output logic [MCDF_ID_W-1:0]              a2f_id_o,
    output logic [DATA_W-1:0]                 a2f_data_o,
    output logic [MCDF_PKGLEN_W-1:0]          a2f_pkglen_sel_o
);

    arb_state_e               state_q, state_d;
    logic [MCDF_ID_W-1:0]     id_q, id_d;
    logic [MCDF_PKGLEN_W-1:0] pkglen_q, pkglen_d;
    logic [MCDF_CNT_W-1:0]    cnt_q, cnt_d;
    logic [MCDF_ID_W-1:0]     rr_ptr;
    logic [MCDF_ID_W-1:0]     win_id;
    logic                     win_vld;
    logic [MCDF_PKGLEN_W-1:0] win_pkglen;

`ifdef ARB_RR_EN
    logic [MCDF_ID_W-1:0]     rr_q, rr_d;
    assign rr_ptr = rr_q;
`else
    // Pointer pinned to the last channel makes the scan start at channel 0.
    assign rr_ptr = MCDF_ID_W'(NUM_CH-1);
`endif

    mcdf_arb_picker #(.NUM_CH(NUM_CH)) u_picker (
        .req_i    (slv_req_i),
        .prio_i   (slv_prio_i),
        .rr_ptr_i (rr_ptr),
        .win_id_o (win_id),
        .win_vld_o(win_vld)
    );

    always_comb begin
        win_pkglen = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (win_id == MCDF_ID_W'(i)) win_pkglen = slv_pkglen_i[MCDF_PKGLEN_W*i +: MCDF_PKGLEN_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        pkglen_d   = pkglen_q;
        cnt_d      = cnt_q;
`ifdef ARB_RR_EN
        rr_d       = rr_q;
`endif
        a2f_val_o  = 1'b0;
        a2f_data_o = '0;
        a2s_ack_o  = '0;

        case (state_q)
            ARB_IDLE: begin
                if (f2a_id_req_i && win_vld) begin
                    state_d  = ARB_GRANT;
                    id_d     = win_id;
                    pkglen_d = win_pkglen;
                    cnt_d    = '0;
                end
            end
            ARB_GRANT: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (id_q == MCDF_ID_W'(i)) begin
                        a2f_val_o    = slv_val_i[i];
                        a2f_data_o   = slv_data_i[DATA_W*i +: DATA_W];
                        a2s_ack_o[i] = f2a_ack_i && slv_val_i[i];
                    end
                end
                // Acks without a valid word are dropped: no pop, no count.
                if (f2a_ack_i && a2f_val_o) begin
                    if (cnt_q == pkglen_decode(pkglen_q) - 6'd1) begin
                        cnt_d   = '0;
                        state_d = ARB_IDLE;
`ifdef ARB_RR_EN
                        rr_d    = id_q;
`endif
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ARB_IDLE;
            id_q     <= '0;
            pkglen_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            pkglen_q <= pkglen_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) rr_q <= MCDF_ID_W'(NUM_CH-1);
        else         rr_q <= rr_d;
    end
`endif

    assign a2f_id_o         = id_q;
    assign a2f_pkglen_sel_o = pkglen_q;

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Directed bench for mcdf_arbiter: priority pick, tie-break, package length, val gaps, reset.
module tb_mcdf_arbiter;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 32;

    logic                  clk_i = 1'b0;
    logic                  rstn_i;
    logic [NUM_CH-1:0]     slv_req_i;
    logic [NUM_CH-1:0]     slv_val_i;
    logic [NUM_CH*32-1:0]  slv_data_i;
    logic [NUM_CH*2-1:0]   slv_prio_i;
    logic [NUM_CH*3-1:0]   slv_pkglen_i;
    logic [NUM_CH-1:0]     a2s_ack_o;
    logic                  f2a_id_req_i;
    logic                  f2a_ack_i;
    logic                  a2f_val_o;
    logic [1:0]            a2f_id_o;
    logic [31:0]           a2f_data_o;
    logic [2:0]            a2f_pkglen_sel_o;

    int nvec = 0;
    int nerr = 0;

    mcdf_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .slv_req_i       (slv_req_i),
        .slv_val_i       (slv_val_i),
        .slv_data_i      (slv_data_i),
        .slv_prio_i      (slv_prio_i),
        .slv_pkglen_i    (slv_pkglen_i),
        .a2s_ack_o       (a2s_ack_o),
        .f2a_id_req_i    (f2a_id_req_i),
        .f2a_ack_i       (f2a_ack_i),
        .a2f_val_o       (a2f_val_o),
        .a2f_id_o        (a2f_id_o),
        .a2f_data_o      (a2f_data_o),
        .a2f_pkglen_sel_o(a2f_pkglen_sel_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] dat(input int n);
        return 32'hD0D0_0000 + 32'(n);
    endfunction

    task automatic set_ch(input int n, input logic [1:0] prio, input logic [2:0] len);
        slv_prio_i[2*n +: 2]   = prio;
        slv_pkglen_i[3*n +: 3] = len;
    endtask

    // Called one step after the grant edge; runs until the arbiter drops back to IDLE.
    task automatic run_pkg(input string tag, input int eid, input int elen,
                           input int glo, input int ghi, input int mod_cyc, output int ncyc);
        int pops, dbad, gbad;
        bit done;
        pops = 0; dbad = 0; gbad = 0; done = 0; ncyc = 0;
        chk({tag, "_id"}, 64'(a2f_id_o), 64'(eid));
        for (int c = 0; c < 80 && !done; c++) begin
            if (c == mod_cyc) begin
                slv_pkglen_i = '0;
                slv_prio_i   = '1;
            end
            slv_val_i[eid] = !(c >= glo && c <= ghi);
            #1;
            if (!a2f_val_o && slv_val_i[eid]) begin
                done = 1;
            end else begin
                if (!slv_val_i[eid] && (a2f_val_o || a2s_ack_o != '0)) gbad++;
                if (a2f_val_o && a2f_data_o !== dat(eid)) dbad++;
                for (int i = 0; i < NUM_CH; i++)
                    if (a2s_ack_o[i] && i != eid) gbad++;
                if (a2s_ack_o[eid]) pops++;
                ncyc++;
                step;
            end
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_pops"}, 64'(pops), 64'(elen));
        chk({tag, "_data"}, 64'(dbad), 64'd0);
        chk({tag, "_gap"},  64'(gbad), 64'd0);
    endtask

    initial begin
        int ncyc, pops;
        rstn_i       = 1'b0;
        slv_req_i    = '0;
        slv_val_i    = '1;
        slv_prio_i   = '0;
        slv_pkglen_i = '0;
        f2a_id_req_i = 1'b1;
        f2a_ack_i    = 1'b1;
        for (int n = 0; n < NUM_CH; n++) slv_data_i[32*n +: 32] = dat(n);

        step;
        step;
        chk("rst_out", {a2f_val_o, a2s_ack_o, a2f_id_o, a2f_pkglen_sel_o, a2f_data_o}, 64'd0);
        rstn_i = 1'b1;

        // 1: single requester ch1, 4-beat package
        set_ch(1, 2'd2, 3'd0);
        slv_req_i = 3'b010;
        #1;
        chk("t1_idle_val", {a2f_val_o, a2s_ack_o, a2f_data_o}, 64'd0);
        step;
        run_pkg("t1", 1, 4, -1, -1, -1, ncyc);
        chk("t1_cyc", 64'(ncyc), 64'd4);
        slv_req_i = '0;
        step;
        chk("t1_stay_idle", 64'(a2f_val_o), 64'd0);
        chk("t1_id_hold", 64'(a2f_id_o), 64'd1);

        // 2: priority beats channel order; idle ch1 with best prio does not matter
        set_ch(0, 2'd3, 3'd0);
        set_ch(1, 2'd0, 3'd0);
        set_ch(2, 2'd1, 3'd1);
        slv_req_i = 3'b101;
        step;
        chk("t2_len_sel_a", 64'(a2f_pkglen_sel_o), 64'd1);
        run_pkg("t2a", 2, 8, -1, -1, -1, ncyc);
        slv_req_i[2] = 1'b0;
        step;
        chk("t2_len_sel_b", 64'(a2f_pkglen_sel_o), 64'd0);
        run_pkg("t2b", 0, 4, -1, -1, -1, ncyc);
        slv_req_i = '0;
        step;

        // 3: equal priority tie-break from a fresh pointer
        rstn_i = 1'b0;
        step;
        rstn_i = 1'b1;
        for (int n = 0; n < NUM_CH; n++) set_ch(n, 2'd0, 3'd0);
        slv_req_i = 3'b111;
        step;
        for (int k = 0; k < 3; k++) begin
`ifdef ARB_RR_EN
            run_pkg("t3", k, 4, -1, -1, -1, ncyc);
`else
            run_pkg("t3", 0, 4, -1, -1, -1, ncyc);
`endif
            if (k < 2) step;
        end
        slv_req_i = '0;
        step;

        // 4: 16-beat package with val gap on grant cycles 3..5
        set_ch(0, 2'd0, 3'd2);
        slv_req_i = 3'b001;
        step;
        run_pkg("t4", 0, 16, 3, 5, -1, ncyc);
        chk("t4_cyc", 64'(ncyc), 64'd19);
        slv_req_i = '0;
        step;

        // 5: saturated length select, register changed mid-package
        set_ch(0, 2'd0, 3'd6);
        slv_req_i = 3'b001;
        step;
        chk("t5_len_sel", 64'(a2f_pkglen_sel_o), 64'd6);
        run_pkg("t5", 0, 32, -1, -1, 10, ncyc);
        chk("t5_cyc", 64'(ncyc), 64'd32);
        chk("t5_len_hold", 64'(a2f_pkglen_sel_o), 64'd6);
        slv_req_i = '0;
        step;

        // 6: reset after 5 of 8 beats, then a fresh package
        set_ch(1, 2'd0, 3'd1);
        slv_req_i = 3'b010;
        step;
        pops = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (a2s_ack_o[1]) pops++;
            step;
        end
        chk("t6_pre_pops", 64'(pops), 64'd5);
        rstn_i = 1'b0;
        #1;
        chk("t6_rst_out", {a2f_val_o, a2s_ack_o, a2f_id_o, a2f_pkglen_sel_o, a2f_data_o}, 64'd0);
        step;
        rstn_i = 1'b1;
        #1;
        chk("t6_idle", {a2f_val_o, a2s_ack_o}, 64'd0);
        step;
        run_pkg("t6", 1, 8, -1, -1, -1, ncyc);
        chk("t6_cyc", 64'(ncyc), 64'd8);
        slv_req_i = '0;
        step;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
